// File: rtl/crc16_rx_checker_if.sv
// Serial receive bus for crc16_rx_checker: bit stream in, deserialised bytes and frame status out.
interface crc16_rx_checker_if;
    logic        bit_valid;
    logic        bit_in;
    logic        last;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_done;
    logic        crc_ok;
    logic        len_err;
    logic [10:0] payload_len;

    modport master (
        output bit_valid, bit_in, last,
        input  byte_out, byte_valid, frame_done, crc_ok, len_err, payload_len
    );

    modport slave (
        input  bit_valid, bit_in, last,
        output byte_out, byte_valid, frame_done, crc_ok, len_err, payload_len
    );
endinterface

// File: rtl/crc16_rx_checker.sv
// Serial frame receiver: deserialises MSB-first bytes, withholds the trailing two CRC bytes
// and checks the CRC-16 residue and frame length at the end of each frame.
module crc16_rx_checker #(
    parameter logic [15:0] POLY        = 16'h1021,
    parameter logic [15:0] INIT        = 16'hFFFF,
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic                clk,
    input  logic                reset,
    crc16_rx_checker_if.slave   bus_io
);

    localparam logic [10:0] MaxLen = 11'(MAX_PAYLOAD);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    state_e      state_q;
    logic [15:0] crc_q;
    logic [6:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  hold0_q;
    logic [7:0]  hold1_q;
    logic [1:0]  hold_cnt_q;
    logic [10:0] emit_cnt_q;
    logic        ovf_q;
    logic [7:0]  byte_out_q;
    logic        byte_valid_q;
    logic        frame_done_q;
    logic        crc_ok_q;
    logic        len_err_q;
    logic [10:0] payload_len_q;

    logic        first;
    logic [15:0] crc_base;
    logic [15:0] crc_d;
    logic [7:0]  shift_d;
    logic [2:0]  bit_cnt_base;
    logic [2:0]  bit_cnt_d;
    logic        byte_done;
    logic [1:0]  byte_cnt_base;
    logic [1:0]  byte_cnt_d;
    logic [1:0]  hold_cnt_base;
    logic        hold_full;
    logic [10:0] emit_base;
    logic [10:0] emit_d;
    logic        emit_now;
    logic        ovf_base;
    logic        ovf_d;
    logic        len_err_d;
    logic        crc_ok_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    // The first bit of a frame sees freshly initialised state rather than leftovers.
    always_comb begin
        first         = (state_q == StIdle);
        crc_base      = first ? INIT : crc_q;
        crc_d         = crc_step(crc_base, bus_io.bit_in);
        shift_d       = {(first ? 7'd0 : shift_q), bus_io.bit_in};
        bit_cnt_base  = first ? 3'd0 : bit_cnt_q;
        bit_cnt_d     = bit_cnt_base + 3'd1;
        byte_done     = (bit_cnt_base == 3'd7);
        byte_cnt_base = first ? 2'd0 : byte_cnt_q;
        byte_cnt_d    = (byte_done && byte_cnt_base != 2'd3) ? byte_cnt_base + 2'd1
                                                              : byte_cnt_base;
        hold_cnt_base = first ? 2'd0 : hold_cnt_q;
        hold_full     = (hold_cnt_base == 2'd2);
        emit_base     = first ? 11'd0 : emit_cnt_q;
        ovf_base      = first ? 1'b0 : ovf_q;
        emit_now      = byte_done && hold_full && (emit_base < MaxLen);
        ovf_d         = ovf_base || (byte_done && hold_full && !(emit_base < MaxLen));
        emit_d        = emit_base + 11'(emit_now);
        len_err_d     = (bit_cnt_d != 3'd0) || (byte_cnt_d < 2'd3) || ovf_d;
        crc_ok_d      = !len_err_d && (crc_d == 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            crc_q         <= INIT;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            hold0_q       <= '0;
            hold1_q       <= '0;
            hold_cnt_q    <= '0;
            emit_cnt_q    <= '0;
            ovf_q         <= 1'b0;
            byte_out_q    <= '0;
            byte_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            crc_ok_q      <= 1'b0;
            len_err_q     <= 1'b0;
            payload_len_q <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus_io.bit_valid) begin
                crc_q      <= crc_d;
                shift_q    <= shift_d[6:0];
                bit_cnt_q  <= bit_cnt_d;
                byte_cnt_q <= byte_cnt_d;
                emit_cnt_q <= emit_d;
                ovf_q      <= ovf_d;
                hold_cnt_q <= hold_cnt_base;
                if (byte_done) begin
                    if (hold_full) begin
                        hold0_q <= hold1_q;
                        hold1_q <= shift_d;
                    end else if (hold_cnt_base == 2'd1) begin
                        hold1_q    <= shift_d;
                        hold_cnt_q <= 2'd2;
                    end else begin
                        hold0_q    <= shift_d;
                        hold_cnt_q <= 2'd1;
                    end
                end
                if (emit_now) begin
                    byte_out_q   <= hold0_q;
                    byte_valid_q <= 1'b1;
                end
                if (bus_io.last) begin
                    state_q       <= StIdle;
                    frame_done_q  <= 1'b1;
                    crc_ok_q      <= crc_ok_d;
                    len_err_q     <= len_err_d;
                    payload_len_q <= emit_d;
                end else begin
                    state_q <= StRecv;
                end
            end
        end
    end

    assign bus_io.byte_out    = byte_out_q;
    assign bus_io.byte_valid  = byte_valid_q;
    assign bus_io.frame_done  = frame_done_q;
    assign bus_io.crc_ok      = crc_ok_q;
    assign bus_io.len_err     = len_err_q;
    assign bus_io.payload_len = payload_len_q;

endmodule

// File: tb/tb_crc16_rx_checker.sv
// Directed bench for crc16_rx_checker: table of frames plus reset-abort, back-to-back and
// payload-overflow sequences.
module tb_crc16_rx_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crc16_rx_checker_if bus ();

    crc16_rx_checker #(
        .POLY        (16'h1021),
        .INIT        (16'hFFFF),
        .MAX_PAYLOAD (1024)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    typedef struct {
        string       name;
        logic [87:0] data;
        int          nbits;
        int          max_gap;
        logic        exp_ok;
        logic        exp_err;
        int          exp_len;
    } vec_t;

    localparam logic [87:0] Good = 88'h31323334353637383929B1;

    vec_t vecs[8];
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [7:0]  rx_q[$];
    int          done_cnt = 0;
    int          ok_cnt = 0;
    logic        last_ok = 1'b0;
    logic        last_err = 1'b0;
    logic [10:0] last_len = '0;

    always @(negedge clk) begin
        if (bus.byte_valid) rx_q.push_back(bus.byte_out);
        if (bus.frame_done) begin
            done_cnt <= done_cnt + 1;
            if (bus.crc_ok) ok_cnt <= ok_cnt + 1;
            last_ok  <= bus.crc_ok;
            last_err <= bus.len_err;
            last_len <= bus.payload_len;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic l, input int gap);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        bus.last      = l;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.last      = 1'b0;
        bus.bit_in    = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [87:0] data, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            send_bit(data[87-i], (i == nbits - 1),
                     (i == nbits - 1) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic settle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".byte_out"}, 32'(bus.byte_out), 32'h0);
        check({tag, ".byte_valid"}, 32'(bus.byte_valid), 32'h0);
        check({tag, ".frame_done"}, 32'(bus.frame_done), 32'h0);
        check({tag, ".crc_ok"}, 32'(bus.crc_ok), 32'h0);
        check({tag, ".len_err"}, 32'(bus.len_err), 32'h0);
        check({tag, ".payload_len"}, 32'(bus.payload_len), 32'h0);
    endtask

    initial begin
        int          done_b;
        int          ok_b;
        int          rx_b;
        logic [87:0] d;
        logic [7:0]  b;

        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.last      = 1'b0;
        reset         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = '{"good",    Good, 88, 0, 1'b1, 1'b0, 9};
        vecs[1] = '{"flip",    88'h31323334343637383929B1, 88, 0, 1'b0, 1'b0, 9};
        vecs[2] = '{"gaps",    Good, 88, 5, 1'b1, 1'b0, 9};
        vecs[3] = '{"bits20",  Good, 20, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{"bits16",  Good, 16, 0, 1'b0, 1'b1, 0};
        vecs[5] = '{"min_ok",  {24'h31C782, 64'h0}, 24, 2, 1'b1, 1'b0, 1};
        vecs[6] = '{"min_bad", {24'h310000, 64'h0}, 24, 0, 1'b0, 1'b0, 1};
        vecs[7] = '{"bit1",    Good, 1, 0, 1'b0, 1'b1, 0};

        foreach (vecs[v]) begin
            done_b = done_cnt;
            rx_b   = rx_q.size();
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].max_gap);
            settle();
            check({vecs[v].name, ".frames"}, 32'(done_cnt - done_b), 32'd1);
            check({vecs[v].name, ".crc_ok"}, 32'(last_ok), 32'(vecs[v].exp_ok));
            check({vecs[v].name, ".len_err"}, 32'(last_err), 32'(vecs[v].exp_err));
            check({vecs[v].name, ".payload_len"}, 32'(last_len), 32'(vecs[v].exp_len));
            check({vecs[v].name, ".nbytes"}, 32'(rx_q.size() - rx_b), 32'(vecs[v].exp_len));
            d = vecs[v].data;
            for (int k = 0; k < vecs[v].exp_len && rx_b + k < rx_q.size(); k++) begin
                b = d[87-8*k -: 8];
                check($sformatf("%s.byte%0d", vecs[v].name, k), 32'(rx_q[rx_b+k]), 32'(b));
            end
        end

        // Abort a frame after 5 payload bytes, then a clean frame must still pass.
        done_b = done_cnt;
        for (int i = 0; i < 40; i++) send_bit(Good[87-i], 1'b0, 0);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_idle_outputs("abort");
        reset = 1'b1;
        settle();
        check("abort.no_done", 32'(done_cnt - done_b), 32'd0);
        rx_b = rx_q.size();
        send_frame(Good, 88, 0);
        settle();
        check("after_abort.frames", 32'(done_cnt - done_b), 32'd1);
        check("after_abort.crc_ok", 32'(last_ok), 32'd1);
        check("after_abort.payload_len", 32'(last_len), 32'd9);
        check("after_abort.nbytes", 32'(rx_q.size() - rx_b), 32'd9);

        // Second frame's first bit lands in the frame_done cycle of the first.
        done_b = done_cnt;
        ok_b   = ok_cnt;
        rx_b   = rx_q.size();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 88; i++) send_bit(Good[87-i], (i == 87), 0);
        end
        settle();
        check("b2b.frames", 32'(done_cnt - done_b), 32'd2);
        check("b2b.ok_frames", 32'(ok_cnt - ok_b), 32'd2);
        check("b2b.nbytes", 32'(rx_q.size() - rx_b), 32'd18);
        check("b2b.payload_len", 32'(last_len), 32'd9);

        // 1025 payload bytes against a 1024-byte limit.
        done_b = done_cnt;
        rx_b   = rx_q.size();
        for (int i = 0; i < 1027; i++) begin
            b = (i < 1025) ? 8'(i) : 8'hA5;
            for (int j = 7; j >= 0; j--) send_bit(b[j], (i == 1026 && j == 0), 0);
        end
        settle();
        check("ovf.frames", 32'(done_cnt - done_b), 32'd1);
        check("ovf.len_err", 32'(last_err), 32'd1);
        check("ovf.crc_ok", 32'(last_ok), 32'd0);
        check("ovf.payload_len", 32'(last_len), 32'd1024);
        check("ovf.nbytes", 32'(rx_q.size() - rx_b), 32'd1024);
        if (rx_q.size() >= rx_b + 1024) begin
            check("ovf.last_byte", 32'(rx_q[rx_b+1023]), 32'hFF);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/crc16_rx_checker.md
CRC16_RX_CHECKER -- requirements
Module: crc16_rx_checker

Interface
REQ-001 Parameter POLY, default 16'h1021, CRC-16 generator polynomial (implicit x^16).
REQ-002 Parameter INIT, default 16'hFFFF, CRC register value loaded at frame start.
REQ-003 Parameter MAX_PAYLOAD, default 1024, maximum payload bytes per frame.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 bit_valid  input  1  bit_in/last qualified this cycle.
REQ-007 bit_in  input  1  serial frame bit; MSB of each byte first.
REQ-008 last  input  1  with bit_valid, marks final bit of frame; ignored when bit_valid=0.
REQ-009 byte_out  output  8  deserialised payload byte.
REQ-010 byte_valid  output  1  one-cycle strobe, byte_out valid.
REQ-011 frame_done  output  1  one-cycle end-of-frame strobe.
REQ-012 crc_ok  output  1  frame residue check passed; valid with frame_done.
REQ-013 len_err  output  1  frame length illegal; valid with frame_done.
REQ-014 payload_len  output  11  payload bytes emitted for the frame; valid with frame_done.

Function
REQ-015 Frame format: payload bytes followed by 2 CRC bytes (CRC-16/CCITT-FALSE, high byte first), all MSB first; no reflection, no final XOR.
REQ-016 FSM states IDLE and RECV; IDLE->RECV on bit_valid=1 with last=0; RECV->IDLE on bit_valid=1 with last=1; IDLE with bit_valid=1 and last=1 is a 1-bit frame and stays IDLE.
REQ-017 First bit of a frame: CRC register loaded with INIT, then updated by that bit; bit count, byte count, and holdback cleared.
REQ-018 Per accepted bit: fb = crc[15]^bit_in; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0); CRC covers payload and CRC bytes.
REQ-019 crc_ok = 1 iff CRC register after final bit equals 16'h0000.
REQ-020 Bits shift into 8-bit deserialiser; every 8th bit completes a byte.
REQ-021 Completed bytes enter a 2-entry holdback FIFO; when a byte completes with the FIFO already holding 2, the oldest is emitted on byte_out with byte_valid the following cycle.
REQ-022 Bytes remaining in holdback at frame end are the CRC bytes; they are discarded, never emitted.
REQ-023 bit_valid=0 cycles inside a frame hold all state; gaps of any length are legal.
REQ-024 frame_done asserts exactly one cycle after the cycle accepting the last bit; crc_ok, len_err, payload_len registered on that edge and held until the next frame_done.
REQ-025 len_err=1 if total bit count is not a multiple of 8, or total bytes < 3, or payload would exceed MAX_PAYLOAD.
REQ-026 When len_err=1, crc_ok=0.
REQ-027 On payload overflow, emission stops at MAX_PAYLOAD bytes; the remainder of the frame is consumed without byte_valid.
REQ-028 payload_len counts only bytes emitted; it saturates at MAX_PAYLOAD.
REQ-029 A bit_valid in the same cycle as frame_done is accepted as the first bit of the next frame.
REQ-030 byte_valid and frame_done never assert without an accepted bit in the prior cycle.

Reset
REQ-031 reset=0 at a clock edge: FSM->IDLE, CRC register->INIT, counters and holdback cleared.
REQ-032 reset=0 at a clock edge: byte_out=0, byte_valid=0, frame_done=0, crc_ok=0, len_err=0, payload_len=0.
REQ-033 Reset mid-frame aborts the frame with no frame_done; the next accepted bit starts a new frame.

Verification
REQ-034 Send "123456789" (0x31..0x39) then 0x29,0xB1, contiguous -> byte_valid x9 with 0x31..0x39 in order, frame_done, crc_ok=1, len_err=0, payload_len=9.
REQ-035 Same frame with bit 0 of byte 0x35 flipped -> 9 bytes emitted, crc_ok=0, len_err=0.
REQ-036 Same frame, random bit_valid gaps (0-5 cycles) -> identical byte sequence and results.
REQ-037 20-bit frame (last on bit 20) -> no byte_valid, frame_done, len_err=1, crc_ok=0; 16-bit frame -> len_err=1.
REQ-038 Assert reset after 5 payload bytes, then send the good frame -> no frame_done for the aborted frame; good frame yields crc_ok=1, payload_len=9.
REQ-039 Back-to-back good frames, first bit of frame 2 in the frame_done cycle -> two frame_done pulses, both crc_ok=1.
